fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/branch_imm_gen.sv | 19 +
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch slice: XLEN, NOP encoding,
// fetch FSM state encoding and base opcode values.
package riscv_pkg;

   localparam int XLEN = 64;

   localparam logic [31:0] NOP = 32'h00000013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      HALT = 2'd3
   } fetch_state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/branch_imm_gen.sv
// B-type immediate extractor, sign-extended to XLEN; purely combinational,
// no flow control.
module branch_imm_gen
   import riscv_pkg::*;
(
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm
);

   logic [12:0] imm13;
   logic        unused_bits;

   assign imm13 = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm   = {{(XLEN-13){imm13[12]}}, imm13};

   // opcode, register and funct3 fields play no part in the offset
   assign unused_bits = ^{instr[24:12], instr[6:0]};

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: ack in cycle N -> instr_valid in N+1; holds
// instr until instr_ready, then fetches pc+4 or the taken-branch target. FETCH_TIMEOUT_EN adds a REQ timeout to HALT.
module fetch_unit
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instr,
   output logic            instr_valid,
   input  logic            instr_ready,
   input  logic            branch,
   input  logic            zero,
   output logic [XLEN-1:0] pc,
   output logic            fetch_err
);

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] pc_q, pc_nxt, pc_tgt, bimm;
   logic [31:0]     instr_q, instr_nxt;
   logic            tmo_hit;

   branch_imm_gen u_bimm (
      .instr (instr_q),
      .imm   (bimm)
   );

   // branch/zero only matter on the retiring edge of HOLD
   assign pc_tgt = pc_q + ((branch && zero) ? bimm : XLEN'(4));

`ifdef FETCH_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   assign tmo_hit = (tmo_cnt == 8'hFF);

   always_ff @(posedge clk) begin
      if (rst)
         tmo_cnt <= 8'd0;
      else if (state == REQ && !imem_ack)
         tmo_cnt <= tmo_cnt + 8'd1;
      else
         tmo_cnt <= 8'd0;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      instr_nxt = instr_q;
      case (state)
         IDLE: state_nxt = REQ;
         REQ: begin
            if (imem_ack) begin
               instr_nxt = imem_rdata;
               state_nxt = HOLD;
            end else if (tmo_hit) begin
               state_nxt = HALT;
            end
         end
         HOLD: begin
            if (instr_ready) begin
               // a misaligned target halts with pc left on the offending branch
               if (pc_tgt[1:0] != 2'b00) begin
                  state_nxt = HALT;
               end else begin
                  pc_nxt    = pc_tgt;
                  state_nxt = REQ;
               end
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pc_q    <= '0;
         instr_q <= NOP;
      end else begin
         state   <= state_nxt;
         pc_q    <= pc_nxt;
         instr_q <= instr_nxt;
      end
   end

   assign imem_req    = (state == REQ);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = (state == HOLD);
   assign fetch_err   = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model and per-cycle compare.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        branch = 1'b0;
   logic        zero = 1'b0;
   logic [63:0] pc;
   logic        fetch_err;

   int n_tot  = 0;
   int n_pass = 0;

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .branch      (branch),
      .zero        (zero),
      .pc          (pc),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   // offset assembled arithmetically from the scattered B-type fields
   function automatic logic [63:0] boff(input logic [31:0] w);
      longint o;
      o = 0;
      if (w[31]) o = o - 4096;
      if (w[7])  o = o + 2048;
      o = o + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
      return 64'(o);
   endfunction

   // model: 0 = waiting to request, 1 = fetching, 2 = holding, 3 = halted
   int          m_ph;
   logic [63:0] m_pc;
   logic [31:0] m_instr;
   int          m_wait;
   bit          chk_en = 1'b0;

   always @(posedge clk) begin
      logic [63:0] tgt;
      if (rst) begin
         m_ph = 0; m_pc = 64'd0; m_instr = 32'h00000013; m_wait = 0;
         chk_en = 1'b1;
      end else begin
         case (m_ph)
            0: m_ph = 1;
            1: begin
               if (imem_ack) begin
                  m_instr = imem_rdata; m_ph = 2; m_wait = 0;
               end else begin
`ifdef FETCH_TIMEOUT_EN
                  if (m_wait == 255) begin m_ph = 3; m_wait = 0; end
                  else m_wait = m_wait + 1;
`endif
               end
            end
            2: if (instr_ready) begin
               tgt = m_pc + ((branch && zero) ? boff(m_instr) : 64'd4);
               if (tgt % 4 != 0) m_ph = 3;
               else begin m_pc = tgt; m_ph = 1; end
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_req",   64'(imem_req),    64'(m_ph == 1));
         chk("cyc_addr",  imem_addr,        m_pc);
         chk("cyc_pc",    pc,               m_pc);
         chk("cyc_valid", 64'(instr_valid), 64'(m_ph == 2));
         chk("cyc_err",   64'(fetch_err),   64'(m_ph == 3));
         chk("cyc_instr", 64'(instr),       64'(m_instr));
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   // called in REQ: ack the current request, return in HOLD
   task automatic fetch(input logic [31:0] w);
      imem_ack = 1'b1; imem_rdata = w;
      step();
      imem_ack = 1'b0;
   endtask

   // called in HOLD: retire the held instruction
   task automatic retire(input logic br, input logic z);
      instr_ready = 1'b1; branch = br; zero = z;
      step();
      instr_ready = 1'b0; branch = 1'b0; zero = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      int nreq;
      rst = 1'b1;
      step(); step();
      chk("rst_req",   64'(imem_req),    64'd0);
      chk("rst_instr", 64'(instr),       64'h13);
      chk("rst_valid", 64'(instr_valid), 64'd0);
      chk("rst_pc",    pc,               64'd0);
      chk("rst_err",   64'(fetch_err),   64'd0);
      rst = 1'b0;
      step();
      chk("first_req",  64'(imem_req), 64'd1);
      chk("first_addr", imem_addr,     64'd0);
      step();
      fetch(32'h00500093);
      chk("lat_valid", 64'(instr_valid), 64'd1);
      chk("lat_instr", 64'(instr),       64'h00500093);
      retire(1'b0, 1'b0);
      chk("adv_addr", imem_addr,     64'd4);
      chk("adv_req",  64'(imem_req), 64'd1);

      for (int i = 0; i < 3; i++) begin fetch(32'h00000013); retire(1'b0, 1'b0); end
      chk("walk_pc", pc, 64'h10);
      fetch(32'hFE000CE3);
      retire(1'b1, 1'b1);
      chk("beq_taken", pc, 64'h08);
      for (int i = 0; i < 2; i++) begin fetch(32'h00000013); retire(1'b0, 1'b0); end
      fetch(32'hFE000CE3);
      retire(1'b1, 1'b0);
      chk("beq_nz", pc, 64'h14);
      fetch(32'hFE000CE3);
      retire(1'b0, 1'b1);
      chk("beq_nbr", pc, 64'h18);

      // reset while requesting, with a late ack right after
      rst = 1'b1;
      step();
      rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
      step();
      imem_ack = 1'b0;
      chk("rstreq_instr", 64'(instr),       64'h13);
      chk("rstreq_valid", 64'(instr_valid), 64'd0);
      chk("rstreq_addr",  imem_addr,        64'd0);
      chk("rstreq_req",   64'(imem_req),    64'd1);

      // back-to-back fetches
      imem_ack = 1'b1; imem_rdata = 32'h00000013; instr_ready = 1'b1;
      nreq = 0;
      for (int i = 0; i < 8; i++) begin
         if (imem_req) begin
            chk("b2b_addr", imem_addr,   64'(4 * nreq));
            chk("b2b_slot", 64'(i),      64'(2 * nreq));
            nreq++;
         end
         step();
      end
      imem_ack = 1'b0; instr_ready = 1'b0;
      chk("b2b_count", 64'(nreq), 64'd4);
      chk("b2b_pc",    pc,        64'h10);

      // long wait without ack
      repeat (300) step();
`ifdef FETCH_TIMEOUT_EN
      chk("tmo_err", 64'(fetch_err), 64'd1);
`else
      chk("wait_req", 64'(imem_req), 64'd1);
      fetch(32'h00A00113);
      chk("wait_instr", 64'(instr),       64'h00A00113);
      chk("wait_valid", 64'(instr_valid), 64'd1);
      retire(1'b0, 1'b0);
      chk("wait_pc", pc, 64'h14);
`endif

      // misaligned target halts until reset
      do_reset();
      for (int i = 0; i < 4; i++) begin fetch(32'h00000013); retire(1'b0, 1'b0); end
      fetch(32'h00000163);
      retire(1'b1, 1'b1);
      chk("halt_err",   64'(fetch_err),   64'd1);
      chk("halt_pc",    pc,               64'h10);
      chk("halt_valid", 64'(instr_valid), 64'd0);
      imem_ack = 1'b1; instr_ready = 1'b1;
      repeat (10) begin
         step();
         chk("halt_req", 64'(imem_req), 64'd0);
      end
      imem_ack = 1'b0; instr_ready = 1'b0;
      do_reset();
      chk("halt_rst_pc",  pc,             64'd0);
      chk("halt_rst_err", 64'(fetch_err), 64'd0);

      // reset beats a retiring instr_ready in the same cycle
      fetch(32'h00000013);
      rst = 1'b1; instr_ready = 1'b1;
      step();
      rst = 1'b0; instr_ready = 1'b0;
      chk("prio_pc",    pc,               64'd0);
      chk("prio_valid", 64'(instr_valid), 64'd0);
      step(); step();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
